// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: SPI slave receiver with synchronisers, multi-word framing and a FWFT output FIFO
module spi_rx_fifo #(
  parameter int DATA_W     = 32,
  parameter int CPOL       = 1,
  parameter int CPHA       = 1,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_SPI_CLK,
  input  logic                          i_SPI_CS_n,
  input  logic                          i_SPI_MOSI,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);
  logic [2:0] sck_s, cs_s, mosi_s;
  logic [DATA_W-1:0] sh, word;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic edge_s, cs_fall, cs_rise, take, done, full, pop, push_ok;
  assign edge_s  = (CPOL == CPHA) ? (!sck_s[2] && sck_s[1]) : (sck_s[2] && !sck_s[1]);
  assign cs_fall = cs_s[2] && !cs_s[1];
  assign cs_rise = !cs_s[2] && cs_s[1];
  assign take    = edge_s && !cs_s[2];
  assign word    = (MSB_FIRST != 0) ? {sh[DATA_W-2:0], mosi_s[2]} : {mosi_s[2], sh[DATA_W-1:1]};
  assign done    = take && cnt == CW'(DATA_W - 1);
  assign full    = count == LW'(FIFO_DEPTH);
  assign pop     = o_valid && i_ready;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign push_ok = done && (!full || pop);
  assign o_valid = count != '0;
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign o_level = count;
  assign o_busy  = !cs_s[2];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_s       <= {3{CPOL[0]}};
      cs_s        <= 3'b111;
      mosi_s      <= '0;
      sh          <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_frame_err <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      sck_s  <= {sck_s[1:0], i_SPI_CLK};
      cs_s   <= {cs_s[1:0], i_SPI_CS_n};
      mosi_s <= {mosi_s[1:0], i_SPI_MOSI};
      if (take) begin
        sh  <= word;
        cnt <= done ? '0 : cnt + 1'b1;
      end
      if (cs_fall || cs_rise) cnt <= '0;
      o_frame_err <= cs_rise && cnt != '0;
      o_ovf       <= done && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push_ok) - LW'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= word;
  end
endmodule
